// File: rtl/bt_pkg.sv
// Shared constants, FSM state type and command decoding for the Bluetooth
// command decoder.
package bt_pkg;

  localparam logic [7:0] HEADER_DEF = 8'hAA;

  localparam logic [7:0] CMD_FWD   = 8'h46;
  localparam logic [7:0] CMD_BACK  = 8'h42;
  localparam logic [7:0] CMD_LEFT  = 8'h4C;
  localparam logic [7:0] CMD_RIGHT = 8'h52;
  localparam logic [7:0] CMD_STOP  = 8'h53;

  localparam logic [1:0] DIR_FWD  = 2'b10;
  localparam logic [1:0] DIR_REV  = 2'b01;
  localparam logic [1:0] DIR_STOP = 2'b00;

  typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_CMD, GOT_SPD} state_t;

  typedef struct packed {
    logic       known;
    logic [1:0] left;
    logic [1:0] right;
    logic       zero_spd;
  } cmd_dec_t;

  function automatic cmd_dec_t decode_cmd(input logic [7:0] cmd);
    cmd_dec_t d;
    d = '{known: 1'b1, left: DIR_STOP, right: DIR_STOP, zero_spd: 1'b0};
    case (cmd)
      CMD_FWD:   begin d.left = DIR_FWD;  d.right = DIR_FWD;  end
      CMD_BACK:  begin d.left = DIR_REV;  d.right = DIR_REV;  end
      CMD_LEFT:  begin d.left = DIR_REV;  d.right = DIR_FWD;  end
      CMD_RIGHT: begin d.left = DIR_FWD;  d.right = DIR_REV;  end
      CMD_STOP:  d.zero_spd = 1'b1;
      default:   d.known = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bt_timeout_cnt.sv
// Cycle timeout counter: counts while enabled, flags the last cycle of the
// window combinationally, then either holds or restarts.
module bt_timeout_cnt #(
  parameter int LIMIT = 2,
  parameter bit HOLD  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // A clear in the same cycle suppresses expiry so an arriving event wins.
  assign expired = en && !clear && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= HOLD ? cnt : '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bt_cmd_decoder.sv
// Frame parser and link watchdog between the Bluetooth UART receiver and the
// motor driver: assembles HEADER/CMD/SPD/CHK frames and drives wheel commands.
module bt_cmd_decoder
  import bt_pkg::*;
#(
  parameter int         CLK_HZ   = 100_000_000,
  parameter logic [7:0] HEADER   = HEADER_DEF,
  parameter int         GAP_CYC  = 500_000,
  parameter int         WDOG_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [1:0] left_dir,
  output logic [1:0] right_dir,
  output logic [7:0] speed,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic       link_lost
);

  // An inter-byte gap longer than one second of clock is never meaningful.
  localparam int GAP_LIM = (GAP_CYC < CLK_HZ) ? GAP_CYC : CLK_HZ;

  state_t     state;
  logic [7:0] cmd_q;
  logic [7:0] spd_q;
  cmd_dec_t   dec;
  logic       chk_byte;
  logic       accept;
  logic       gap_exp;
  logic       wdog_exp;

  assign dec      = decode_cmd(cmd_q);
  assign chk_byte = rx_valid && (state == GOT_SPD);
  assign accept   = chk_byte && (rx_data == (HEADER ^ cmd_q ^ spd_q)) && dec.known;

  bt_timeout_cnt #(.LIMIT(GAP_LIM), .HOLD(1'b0)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_valid),
    .en      (state != IDLE),
    .expired (gap_exp)
  );

  bt_timeout_cnt #(.LIMIT(WDOG_CYC), .HOLD(1'b1)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .en      (!link_lost),
    .expired (wdog_exp)
  );

  // CMD and SPD latches are data-only; the FSM state qualifies them.
  always_ff @(posedge clk) begin
    if (rx_valid && state == GOT_HDR) cmd_q <= rx_data;
    if (rx_valid && state == GOT_CMD) spd_q <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      left_dir  <= DIR_STOP;
      right_dir <= DIR_STOP;
      speed     <= 8'h00;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      link_lost <= 1'b1;
    end else begin
      pkt_ok  <= 1'b0;
      pkt_err <= 1'b0;
      // Expiry is applied first so an accept in the same cycle overrides it.
      if (wdog_exp) begin
        left_dir  <= DIR_STOP;
        right_dir <= DIR_STOP;
        speed     <= 8'h00;
        link_lost <= 1'b1;
      end
      if (rx_valid) begin
        case (state)
          IDLE:    if (rx_data == HEADER) state <= GOT_HDR;
          GOT_HDR: state <= GOT_CMD;
          GOT_CMD: state <= GOT_SPD;
          GOT_SPD: begin
            state <= IDLE;
            if (accept) begin
              left_dir  <= dec.left;
              right_dir <= dec.right;
              speed     <= dec.zero_spd ? 8'h00 : spd_q;
              pkt_ok    <= 1'b1;
              link_lost <= 1'b0;
            end else begin
              pkt_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (gap_exp) begin
        state   <= IDLE;
        pkt_err <= 1'b1;
      end
    end
  end

endmodule
